// File: rtl/power_trig_pkg.sv
// Shared definitions for the power-trigger sequencer: state encoding, register
// offsets relative to BASE, and control-word bit positions.
package power_trig_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHold = 3'd1,
        StWait = 3'd2,
        StCap  = 3'd3,
        StDone = 3'd4
    } state_e;

    localparam logic [1:0] RegHoldoff = 2'd0;
    localparam logic [1:0] RegLen     = 2'd1;
    localparam logic [1:0] RegTimeout = 2'd2;
    localparam logic [1:0] RegCtrl    = 2'd3;

    localparam int unsigned CtrlArm   = 0;
    localparam int unsigned CtrlCont  = 1;
    localparam int unsigned CtrlAbort = 2;

    function automatic logic is_running(state_e s);
        return (s == StHold) || (s == StWait) || (s == StCap);
    endfunction

endpackage

// File: rtl/strobe_counter.sv
// Strobe-qualified counter with synchronous clear; o_tc flags the strobe that
// brings the count up to i_target (i_target must be non-zero when used).
module strobe_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign o_tc = i_inc && !i_clr && (w_cnt_inc == i_target);

endmodule

// File: rtl/power_trig_seq.sv
// Power-trigger sequencer: holdoff, wait-for-trigger with timeout and a
// strobe-counted capture gate, programmed over the settings bus.
module power_trig_seq
    import power_trig_pkg::*;
#(
    parameter logic [7:0]  BASE  = 8'h00,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        strobe,
    input  logic        trig,
    output logic        run,
    output logic        capture,
    output logic        done,
    output logic [31:0] status
);

    logic [CNT_W-1:0] r_holdoff, r_len, r_sh_holdoff, r_sh_len, r_trig_cnt;
    logic [31:0]      r_timeout, r_sh_timeout, r_to_cnt;
    logic             r_cont, r_arm, r_abort, r_to_flag;
    logic             r_run, r_capture, r_done;
    state_e           r_state, w_nxt;

    logic [7:0]  w_off;
    logic        w_hit, w_hold_tc, w_cap_tc, w_to_hit;
    logic        w_arm_take, w_to_fire, w_trig_take;
    logic [15:0] w_trig16;

    assign w_off = set_addr - BASE;
    assign w_hit = set_stb && (w_off[7:2] == 6'd0);

    // Settings registers; arm and abort are one-cycle command pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_holdoff <= '0;
            r_len     <= '0;
            r_timeout <= '0;
            r_cont    <= 1'b0;
            r_arm     <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_arm   <= 1'b0;
            r_abort <= 1'b0;
            if (w_hit) begin
                unique case (w_off[1:0])
                    RegHoldoff: r_holdoff <= set_data[CNT_W-1:0];
                    RegLen:     r_len     <= set_data[CNT_W-1:0];
                    RegTimeout: r_timeout <= set_data;
                    RegCtrl: begin
                        r_cont  <= set_data[CtrlCont];
                        r_arm   <= set_data[CtrlArm];
                        r_abort <= set_data[CtrlAbort];
                    end
                endcase
            end
        end
    end

    strobe_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (r_state != StHold),
        .i_inc    (strobe),
        .i_target (r_sh_holdoff),
        .o_tc     (w_hold_tc)
    );

    strobe_counter #(.CNT_W(CNT_W)) u_cap_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clr    (r_state != StCap),
        .i_inc    (strobe),
        .i_target (r_sh_len),
        .o_tc     (w_cap_tc)
    );

    assign w_to_hit    = (r_sh_timeout != 32'd0) && (r_to_cnt == r_sh_timeout - 32'd1);
    assign w_arm_take  = (r_state == StIdle) && r_arm && !r_abort;
    assign w_trig_take = (r_state == StWait) && trig && !r_abort;
    assign w_to_fire   = (r_state == StWait) && !trig && w_to_hit && !r_abort;

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            StIdle: if (r_arm) w_nxt = (r_holdoff == '0) ? StWait : StHold;
            StHold: if (w_hold_tc) w_nxt = StWait;
            StWait: begin
                if (trig) begin
                    w_nxt = (r_sh_len == '0) ? StDone : StCap;
                end else if (w_to_hit) begin
                    w_nxt = StDone;
                end
            end
            StCap:  if (w_cap_tc) w_nxt = StDone;
            StDone: begin
                if (r_cont && !r_to_flag) begin
                    w_nxt = (r_sh_holdoff == '0) ? StWait : StHold;
                end else begin
                    w_nxt = StIdle;
                end
            end
            default: w_nxt = StIdle;
        endcase
        if (r_abort) w_nxt = StIdle;
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_run        <= 1'b0;
            r_capture    <= 1'b0;
            r_done       <= 1'b0;
            r_sh_holdoff <= '0;
            r_sh_len     <= '0;
            r_sh_timeout <= '0;
            r_to_cnt     <= '0;
            r_to_flag    <= 1'b0;
            r_trig_cnt   <= '0;
        end else begin
            r_state   <= w_nxt;
            r_run     <= is_running(w_nxt);
            r_capture <= (w_nxt == StCap);
            r_done    <= (w_nxt == StDone);
            r_to_cnt  <= (r_state == StWait) ? r_to_cnt + 32'd1 : 32'd0;
            if (w_arm_take) begin
                r_sh_holdoff <= r_holdoff;
                r_sh_len     <= r_len;
                r_sh_timeout <= r_timeout;
                r_to_flag    <= 1'b0;
            end
            if (w_to_fire) r_to_flag <= 1'b1;
            if (w_trig_take && (r_trig_cnt != '1)) r_trig_cnt <= r_trig_cnt + CNT_W'(1);
        end
    end

    assign w_trig16 = 16'(r_trig_cnt);
    assign run      = r_run;
    assign capture  = r_capture;
    assign done     = r_done;
    assign status   = {w_trig16, 8'h00, 3'b000, r_cont, r_to_flag, r_state};

endmodule

// File: tb/tb_power_trig_seq.sv
// Directed and randomized bench for power_trig_seq; expected traces come from a
// time-walking model of holdoff/wait/capture/done windows over stimulus arrays.
module tb_power_trig_seq;

    localparam logic [7:0]  BASE  = 8'h40;
    localparam int unsigned CNT_W = 8;
    localparam int          NMAX  = 700;
    localparam int          SAT   = 255;

    logic        clk = 1'b0, reset_n = 1'b0, set_stb = 1'b0, strobe = 1'b0, trig = 1'b0;
    logic [7:0]  set_addr = 8'h00;
    logic [31:0] set_data = 32'h0;
    logic        run, capture, done;
    logic [31:0] status;

    int n_tests = 0, n_fail = 0;
    int cur_hold = 0, cur_len = 0, cur_to = 0;
    int exp_trig = 0;
    bit exp_to = 1'b0;
    int oc, od;
    bit stb_a[NMAX], trig_a[NMAX], e_run[NMAX], e_cap[NMAX], e_done[NMAX];

    power_trig_seq #(.BASE(BASE), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .strobe   (strobe),
        .trig     (trig),
        .run      (run),
        .capture  (capture),
        .done     (done),
        .status   (status)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int off, input logic [31:0] data);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = BASE + 8'(off); set_data = data;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic cfg(input int h, input int l, input int to);
        wr(0, h); wr(1, l); wr(2, to);
        cur_hold = h; cur_len = l; cur_to = to;
    endtask

    // stb_mode: 0 odd cycles, 1 every cycle, 2 random; trig_mode: 0 none, 1 always, 2 random.
    task automatic stim(input int stb_mode, input int trig_mode);
        for (int i = 0; i < NMAX; i++) begin
            stb_a[i]  = (stb_mode == 0) ? bit'(i % 2) : (stb_mode == 1) ? 1'b1
                                                      : bit'($urandom_range(0, 1));
            trig_a[i] = (trig_mode == 1) ? 1'b1
                      : (trig_mode == 2) ? ($urandom_range(0, 9) == 0) : 1'b0;
        end
    endtask

    // Cycle 0 carries the arm write; outputs are checked every cycle against the model.
    task automatic scen(input string tag, input int n, input bit cont, input int abort_t,
                        input bit abort_arm, input int wr_t, input int wr_off,
                        input logic [31:0] wr_data, input bit do_status,
                        output int obs_cap, output int obs_done);
        int sh_hold, sh_len, sh_to, t, k, n_st, n_trig_ev;
        bit got_trig, to_hit, to_ev, bad;
        sh_hold = cur_hold; sh_len = cur_len; sh_to = cur_to;
        for (int i = 0; i < n; i++) begin
            e_run[i] = 1'b0; e_cap[i] = 1'b0; e_done[i] = 1'b0;
        end
        n_trig_ev = 0; to_ev = 1'b0; t = 2;
        while (t < n) begin
            n_st = 0;
            while (n_st < sh_hold && t < n) begin
                e_run[t] = 1'b1; if (stb_a[t]) n_st++; t++;
            end
            k = 0; got_trig = 1'b0; to_hit = 1'b0;
            while (!got_trig && !to_hit && t < n) begin
                e_run[t] = 1'b1;
                if (trig_a[t]) begin
                    got_trig = 1'b1;
                    if (abort_t < 0 || t <= abort_t) n_trig_ev++;
                end else begin
                    k++;
                    if (sh_to != 0 && k == sh_to) begin
                        to_hit = 1'b1;
                        if (abort_t < 0 || t <= abort_t) to_ev = 1'b1;
                    end
                end
                t++;
            end
            n_st = 0;
            while (got_trig && n_st < sh_len && t < n) begin
                e_run[t] = 1'b1; e_cap[t] = 1'b1; if (stb_a[t]) n_st++; t++;
            end
            if (t < n) e_done[t] = 1'b1;
            t++;
            if (!cont || to_hit) break;
        end
        if (abort_t >= 0) begin
            for (int i = abort_t + 2; i < n; i++) begin
                e_run[i] = 1'b0; e_cap[i] = 1'b0; e_done[i] = 1'b0;
            end
        end
        if (wr_off == 1) cur_len = int'(wr_data[CNT_W-1:0]);

        bad = 1'b0; obs_cap = 0; obs_done = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            set_stb = 1'b0;
            if (i == 0) begin
                set_stb = 1'b1; set_addr = BASE + 8'd3; set_data = {29'd0, 1'b0, cont, 1'b1};
            end else if (i == abort_t) begin
                set_stb = 1'b1; set_addr = BASE + 8'd3; set_data = {29'd0, 1'b1, cont, abort_arm};
            end else if (i == wr_t) begin
                set_stb = 1'b1; set_addr = BASE + 8'(wr_off); set_data = wr_data;
            end
            strobe = stb_a[i]; trig = trig_a[i];
            @(negedge clk);
            if (capture === 1'b1) obs_cap++;
            if (done === 1'b1) obs_done++;
            if (!bad) begin
                n_tests++;
                assert ({run, capture, done} === {e_run[i], e_cap[i], e_done[i]}) else begin
                    n_fail++; bad = 1'b1;
                    $error("FAIL %s cycle %0d: run/capture/done observed %b expected %b", tag, i,
                           {run, capture, done}, {e_run[i], e_cap[i], e_done[i]});
                end
            end
        end
        @(posedge clk); #1;
        set_stb = 1'b0; strobe = 1'b0; trig = 1'b0;
        if (do_status) begin
            exp_trig = (exp_trig + n_trig_ev > SAT) ? SAT : exp_trig + n_trig_ev;
            exp_to = to_ev;
            @(negedge clk);
            check({tag, "_status"}, status,
                  {16'(exp_trig), 8'h00, 3'b000, cont, exp_to, 3'b000});
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, run, capture, done}, 32'd0);
        check("reset_status", status, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // One-shot with a trig pulse in HOLD that must be ignored.
        cfg(4, 8, 0); stim(0, 0); trig_a[5] = 1'b1; trig_a[19] = 1'b1;
        scen("oneshot", 60, 1'b0, 56, 1'b0, -1, 0, 0, 1'b1, oc, od);
        check("oneshot_cap_cycles", oc, 16);
        check("oneshot_done_pulses", od, 1);

        cfg(2, 3, 0); stim(0, 0); trig_a[10] = 1'b1; trig_a[30] = 1'b1; trig_a[50] = 1'b1;
        scen("continuous", 72, 1'b1, 66, 1'b0, -1, 0, 0, 1'b1, oc, od);
        check("continuous_done_pulses", od, 3);

        cfg(0, 3, 50); stim(0, 0);
        scen("timeout", 70, 1'b1, -1, 1'b0, -1, 0, 0, 1'b1, oc, od);
        check("timeout_done_pulses", od, 1);

        cfg(1, 20, 0); stim(0, 0); trig_a[10] = 1'b1;
        scen("abort_arm", 30, 1'b1, 15, 1'b1, -1, 0, 0, 1'b1, oc, od);
        check("abort_no_done", od, 0);

        cfg(0, 0, 0); stim(0, 0); trig_a[5] = 1'b1;
        scen("len0", 15, 1'b0, -1, 1'b0, -1, 0, 0, 1'b1, oc, od);
        check("len0_no_capture", oc, 0);
        check("len0_done", od, 1);

        cfg(3, 5, 0); stim(0, 0); trig_a[12] = 1'b1;
        scen("len_rewrite", 30, 1'b0, -1, 1'b0, 15, 1, 32'd2, 1'b1, oc, od);
        check("len_rewrite_cap_cycles", oc, 9);

        stim(0, 0); trig_a[12] = 1'b1;
        scen("new_len_busy_arm", 30, 1'b0, -1, 1'b0, 14, 3, 32'd1, 1'b1, oc, od);
        check("new_len_cap_cycles", oc, 3);

        for (int r = 0; r < 8; r++) begin
            cfg($urandom_range(0, 5), $urandom_range(0, 5),
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 30));
            stim(2, 2);
            scen("random", 150, bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(20, 140) : 146,
                 bit'($urandom_range(0, 1)), -1, 0, 0, 1'b1, oc, od);
        end

        cfg(0, 0, 0); stim(3, 1);
        scen("saturate", 600, 1'b1, 596, 1'b0, -1, 0, 0, 1'b1, oc, od);

        // Asynchronous reset in the middle of a capture window.
        cfg(0, 10, 0); stim(0, 0); trig_a[4] = 1'b1;
        scen("pre_reset", 8, 1'b0, -1, 1'b0, -1, 0, 0, 1'b0, oc, od);
        check("capture_before_reset", {31'd0, capture}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {29'd0, run, capture, done}, 32'd0);
        check("async_reset_status", status, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cur_hold = 0; cur_len = 0; cur_to = 0; exp_trig = 0; exp_to = 1'b0;

        cfg(2, 3, 0); stim(0, 0); trig_a[12] = 1'b1;
        scen("after_reset", 30, 1'b0, -1, 1'b0, -1, 0, 0, 1'b1, oc, od);
        check("after_reset_done", od, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
